// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - mode encodings, pattern lengths and pattern lookup for the LED sequencer
//
// Purpose: shared definitions for led_pattern_ctrl and its prescaler.
// Ports: none (package).
package led_pkg;

  typedef enum logic [1:0] {
    FILL_DRAIN = 2'd0,
    RUN        = 2'd1,
    BOUNCE     = 2'd2,
    BLINK      = 2'd3
  } mode_t;

  localparam logic [4:0] LEN_FILL_DRAIN = 5'd16;
  localparam logic [4:0] LEN_RUN        = 5'd8;
  localparam logic [4:0] LEN_BOUNCE     = 5'd14;
  localparam logic [4:0] LEN_BLINK      = 5'd2;

  localparam logic [7:0] Q_RESET = 8'h01;

  function automatic logic [4:0] pattern_len(input mode_t m);
    logic [4:0] len;
    case (m)
      FILL_DRAIN: len = LEN_FILL_DRAIN;
      RUN:        len = LEN_RUN;
      BOUNCE:     len = LEN_BOUNCE;
      default:    len = LEN_BLINK;
    endcase
    return len;
  endfunction

  // Indices beyond the pattern length read as index 0.
  function automatic logic [7:0] pattern_value(input mode_t m, input logic [3:0] idx);
    logic [3:0] i;
    logic [7:0] v;
    i = ({1'b0, idx} >= pattern_len(m)) ? 4'd0 : idx;
    v = 8'h00;
    case (m)
      FILL_DRAIN: begin
        case (i)
          4'd0:  v = 8'h01;
          4'd1:  v = 8'h03;
          4'd2:  v = 8'h07;
          4'd3:  v = 8'h0F;
          4'd4:  v = 8'h1F;
          4'd5:  v = 8'h3F;
          4'd6:  v = 8'h7F;
          4'd7:  v = 8'hFF;
          4'd8:  v = 8'hFE;
          4'd9:  v = 8'hFC;
          4'd10: v = 8'hF8;
          4'd11: v = 8'hF0;
          4'd12: v = 8'hE0;
          4'd13: v = 8'hC0;
          4'd14: v = 8'h80;
          default: v = 8'h00;
        endcase
      end
      RUN: begin
        v = 8'h01 << i[2:0];
      end
      BOUNCE: begin
        // Up the bank for indices 0..7, back down for 8..13.
        if (i < 4'd8) v = 8'h01 << i[2:0];
        else          v = 8'h01 << 3'(4'd14 - i);
      end
      default: begin
        v = (i == 4'd0) ? 8'hFF : 8'h00;
      end
    endcase
    return v;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - programmable step prescaler
//
// Purpose: produces a single-cycle tick every (DIV << speed) enabled clocks.
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous active-low reset
//   enable - 1 counts, 0 freezes the count and suppresses tick
//   speed  - period exponent, period = DIV << speed
//   tick   - combinational, high in the cycle the period completes
module tick_gen #(
  parameter int DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] speed,
  output logic       tick
);

  localparam int CW = $clog2(DIV << 3);

  logic [CW-1:0] cnt;
  logic [CW-1:0] limit;

  always_comb begin
    limit = CW'(DIV - 1);
    case (speed)
      2'd0:    limit = CW'(DIV - 1);
      2'd1:    limit = CW'((DIV << 1) - 1);
      2'd2:    limit = CW'((DIV << 2) - 1);
      default: limit = CW'((DIV << 3) - 1);
    endcase
  end

  // >= rather than == so a speed drop below the current count ticks at once.
  assign tick = enable && (cnt >= limit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// rtl/led_pattern_ctrl.sv - timed, mode-selectable 8-LED pattern sequencer
//
// Purpose: steps one of four light patterns on each prescaler tick.
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   enable     - 1 runs, 0 freezes prescaler and pattern
//   mode       - requested pattern, taken on the next tick
//   speed      - step period exponent
//   q          - registered LED drive
//   step       - one-cycle pulse when q takes a new value
//   frame_done - one-cycle pulse on the step that wraps to index 0
module led_pattern_ctrl
  import led_pkg::*;
#(
  parameter int DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] mode,
  input  logic [1:0] speed,
  output logic [7:0] q,
  output logic       step,
  output logic       frame_done
);

  logic       tick;
  mode_t      active;
  logic [3:0] idx;
  logic [3:0] eff_idx;
  logic [3:0] next_idx;
  logic [4:0] len;
  logic       wrap;
  mode_t      req;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .speed  (speed),
    .tick   (tick)
  );

  assign req = mode_t'(mode);
  assign len = pattern_len(active);

  // An out-of-range index behaves as index 0 so the sequencer self-recovers.
  always_comb begin
    eff_idx  = ({1'b0, idx} >= len) ? 4'd0 : idx;
    wrap     = ({1'b0, eff_idx} == (len - 5'd1));
    next_idx = wrap ? 4'd0 : eff_idx + 4'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active     <= FILL_DRAIN;
      idx        <= 4'd0;
      q          <= Q_RESET;
      step       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      step       <= 1'b0;
      frame_done <= 1'b0;
      if (tick) begin
        step <= 1'b1;
        if (req != active) begin
          active <= req;
          idx    <= 4'd0;
          q      <= pattern_value(req, 4'd0);
        end else begin
          idx        <= next_idx;
          q          <= pattern_value(active, next_idx);
          frame_done <= wrap;
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb/tb_led_pattern_ctrl.sv - self-checking bench for led_pattern_ctrl
module tb_led_pattern_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [1:0] speed = 2'd0;
  logic [7:0] q;
  logic       step;
  logic       frame_done;

  always #5 clk = ~clk;

  led_pattern_ctrl #(.DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .mode       (mode),
    .speed      (speed),
    .q          (q),
    .step       (step),
    .frame_done (frame_done)
  );

  int total = 0;
  int bad = 0;

  // Reference model state
  int       m_cnt;
  int       m_mode;
  int       m_idx;
  bit [7:0] m_q;
  bit       m_step;
  bit       m_fd;
  int       plen [4] = '{16, 8, 14, 2};

  function automatic bit [7:0] model_pat(int m, int i);
    int v;
    case (m)
      0: v = (i < 8) ? ((1 << (i + 1)) - 1) : ((255 << (i - 7)) & 255);
      1: v = 1 << i;
      2: v = (i < 8) ? (1 << i) : (1 << (14 - i));
      default: v = (i == 0) ? 255 : 0;
    endcase
    return 8'(v);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_mode = 0; m_idx = 0; m_q = 8'h01; m_step = 0; m_fd = 0;
  endtask

  task automatic model_edge();
    int lim;
    if (!reset) begin
      model_reset();
    end else begin
      lim = (4 << speed) - 1;
      m_step = 0;
      m_fd = 0;
      if (enable && m_cnt >= lim) begin
        m_cnt = 0;
        m_step = 1;
        if (int'(mode) != m_mode) begin
          m_mode = int'(mode);
          m_idx = 0;
        end else begin
          m_idx = (m_idx + 1) % plen[m_mode];
          m_fd = (m_idx == 0);
        end
        m_q = model_pat(m_mode, m_idx);
      end else if (enable) begin
        m_cnt++;
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      chk("q", 32'(q), 32'(m_q));
      chk("step", 32'(step), 32'(m_step));
      chk("frame_done", 32'(frame_done), 32'(m_fd));
    end
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_q", 32'(q), 32'h01);
    chk("rst_step", 32'(step), 32'h0);
    chk("rst_fd", 32'(frame_done), 32'h0);

    // Fill/drain full frame
    mode = 2'd0; speed = 2'd0; enable = 1'b1; reset = 1'b1;
    cyc(3);
    chk("s1_no_early_step", 32'(step), 32'h0);
    cyc(1);
    chk("s1_first_q", 32'(q), 32'h03);
    cyc(60);
    chk("s1_wrap_q", 32'(q), 32'h01);
    chk("s1_wrap_fd", 32'(frame_done), 32'h1);

    // Mid-frame switch to blink at 0F
    cyc(12);
    chk("s3_at_0f", 32'(q), 32'h0F);
    mode = 2'd3;
    cyc(4);
    chk("s3_ff", 32'(q), 32'hFF);
    chk("s3_ff_fd", 32'(frame_done), 32'h0);
    cyc(4);
    chk("s3_00", 32'(q), 32'h00);
    cyc(4);
    chk("s3_ff2", 32'(q), 32'hFF);
    chk("s3_ff2_fd", 32'(frame_done), 32'h1);

    // Bounce full frame
    mode = 2'd2;
    cyc(4);
    chk("s2_switch_q", 32'(q), 32'h01);
    chk("s2_switch_fd", 32'(frame_done), 32'h0);
    cyc(28);
    chk("s2_peak", 32'(q), 32'h80);
    cyc(28);
    chk("s2_end_q", 32'(q), 32'h01);
    chk("s2_end_fd", 32'(frame_done), 32'h1);

    // Pause at cnt=2 for 10 clocks
    cyc(2);
    enable = 1'b0;
    cyc(10);
    chk("s4_frozen_q", 32'(q), 32'h01);
    enable = 1'b1;
    cyc(1);
    chk("s4_resume_wait", 32'(step), 32'h0);
    cyc(1);
    chk("s4_resume_step", 32'(step), 32'h1);

    // Slow speed then drop at cnt=20
    speed = 2'd3;
    cyc(31);
    chk("s5_slow_wait", 32'(step), 32'h0);
    cyc(1);
    chk("s5_slow_step", 32'(step), 32'h1);
    cyc(20);
    speed = 2'd0;
    cyc(1);
    chk("s5_drop_step", 32'(step), 32'h1);
    cyc(4);
    chk("s5_fast_step", 32'(step), 32'h1);

    // Async reset while q=3F and step is high
    mode = 2'd0;
    cyc(4);
    cyc(20);
    chk("s6_at_3f", 32'(q), 32'h3F);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("s6_async_q", 32'(q), 32'h01);
    chk("s6_async_step", 32'(step), 32'h0);
    chk("s6_async_fd", 32'(frame_done), 32'h0);
    #2 reset = 1'b1;
    cyc(3);
    chk("s6_rel_wait", 32'(step), 32'h0);
    cyc(1);
    chk("s6_rel_step", 32'(step), 32'h1);
    chk("s6_rel_q", 32'(q), 32'h03);

    // Randomized run against the model
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) speed = 2'($urandom_range(0, 3));
      enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 799) == 0) begin
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("rnd_async_q", 32'(q), 32'h01);
        #2 reset = 1'b1;
      end
      cyc(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
